// File: rtl/seq_divider.sv
// Multi-cycle signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, with sign fix-up applied in a final cycle.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exc_q, exc_d;

    logic             start;
    logic             div_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_shift;
    logic             ge;
    logic [WIDTH-1:0] sub_lo;

    assign start    = (state_q == IDLE) && ctrl_DIV;
    assign div_zero = (data_operandB == '0);
    assign abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // The partial remainder is logically WIDTH+1 bits, but after each step it
    // is below |B| <= 2^(WIDTH-1), so only the shifted value needs the top bit.
    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign ge        = (rem_shift >= {1'b0, dvs_q});
    assign sub_lo    = rem_shift[WIDTH-1:0] - dvs_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ctrl_DIV) state_d = div_zero ? DONE : ITER;
            ITER: if (cnt_q == LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;
        case (state_q)
            IDLE: begin
                if (start && div_zero) begin
                    result_d    = '0;
                    remainder_d = '0;
                    exc_d       = 1'b1;
                end else if (start) begin
                    dvd_d    = abs_a;
                    dvs_d    = abs_b;
                    rem_d    = '0;
                    quo_d    = '0;
                    cnt_d    = '0;
                    sign_q_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    sign_r_d = data_operandA[WIDTH-1];
                    // MIN/-1 yields the wrapped quotient naturally; only the flag is special.
                    ovf_d    = (data_operandA == MIN_NEG) && (data_operandB == '1);
                end
            end
            ITER: begin
                rem_d = ge ? sub_lo : rem_shift[WIDTH-1:0];
                dvd_d = dvd_q << 1;
                quo_d = {quo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + 1'b1;
            end
            FIX: begin
                result_d    = sign_q_q ? -quo_q : quo_q;
                remainder_d = sign_r_q ? -rem_q : rem_q;
                exc_d       = ovf_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy           = (state_q != IDLE);
        data_resultRDY = (state_q == DONE);
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against a plain-arithmetic model.
module tb_seq_divider;

    logic        clock;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int total = 0;
    int bad   = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0) begin
            q = 0; r = 0; e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0; e = 1'b1;
        end else begin
            q = sa / sb; r = sa % sb; e = 1'b0;
        end
    endfunction

    // pulse_at: sample index after the start edge at which a stray start is driven (-1 = none)
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_at);
        logic [31:0] eq, er;
        logic        ee;
        int          k, busy_low, exp_lat;
        model(a, b, eq, er, ee);
        exp_lat = (b == 0) ? 0 : 33;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        k = 0;
        busy_low = 0;
        while (!data_resultRDY && k < 40) begin
            if (!busy) busy_low++;
            if (k == pulse_at) begin
                ctrl_DIV = 1'b1;
                data_operandB = 32'h0;
            end else begin
                ctrl_DIV = 1'b0;
            end
            @(posedge clock);
            #1;
            k++;
        end
        ctrl_DIV = 1'b0;
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_busy_low"}, busy_low, 0);
        chk({tag, "_busy_at_rdy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_q"}, data_result, eq);
        chk({tag, "_r"}, data_remainder, er);
        chk({tag, "_exc"}, {31'b0, data_exception}, {31'b0, ee});
        @(posedge clock);
        #1;
        chk({tag, "_rdy_fall"}, {31'b0, data_resultRDY}, 32'd0);
        chk({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
        chk({tag, "_q_hold"}, data_result, eq);
        if (pulse_at >= 0) begin
            int extra = 0;
            for (int i = 0; i < 6; i++) begin
                if (data_resultRDY || busy) extra++;
                @(posedge clock);
                #1;
            end
            chk({tag, "_no_extra_op"}, extra, 0);
        end
    endtask

    task automatic run_abort(input logic [31:0] a, input logic [31:0] b, input int at);
        int rdy_seen = 0;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        for (int i = 0; i < at; i++) begin
            if (data_resultRDY) rdy_seen++;
            @(posedge clock);
            #1;
        end
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_q", data_result, 32'd0);
        chk("abort_r", data_remainder, 32'd0);
        chk("abort_exc", {31'b0, data_exception}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (data_resultRDY) rdy_seen++;
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (data_resultRDY) rdy_seen++;
            @(posedge clock);
            #1;
        end
        chk("abort_no_rdy", rdy_seen, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset_n = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_q", data_result, 32'd0);
        chk("reset_r", data_remainder, 32'd0);
        chk("reset_exc", {31'b0, data_exception}, 32'd0);
        chk("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("pos_pos", 32'd100, 32'd7, -1);
        run_op("neg_pos", -32'sd100, 32'd7, -1);
        run_op("pos_neg", 32'd100, -32'sd7, -1);
        run_op("neg_neg", -32'sd100, -32'sd7, -1);
        run_op("div_zero", 32'd5, 32'd0, -1);
        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("min_by_one", 32'h8000_0000, 32'd1, -1);
        run_op("ignored_start", 32'd12345, 32'd10, 10);
        run_op("big_divisor", 32'd3, 32'h8000_0000, -1);

        run_abort(32'd1000, 32'd3, 20);
        run_op("after_abort", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = $urandom_range(1, 100);
            if (i % 4 == 1) rb = -rb;
            run_op($sformatf("rand%0d", i), ra, rb, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
